// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and constants for the symbol-sequence detector.
// Holds the FSM state type, the default geometry and the reset-time pattern.
package seq_detect_ctrl_pkg;

  localparam int unsigned SYM_W   = 3;
  localparam int unsigned MAX_LEN = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHunt
  } state_e;

  // Slot 0 is the first symbol of the sequence.
  localparam logic [SYM_W-1:0] DEFAULT_PATTERN [MAX_LEN] = '{
    3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5
  };

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational window comparator: the incoming symbol plus the previous len-1
// accepted symbols (history[0] = most recent) against pattern slots 0..len-1.
module seq_window_cmp #(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MAX_LEN = 8
) (
  input  logic [MAX_LEN-1:0][SYM_W-1:0] history,
  input  logic [SYM_W-1:0]              sym,
  input  logic [MAX_LEN-1:0][SYM_W-1:0] pattern,
  input  logic [3:0]                    len,
  output logic                          match
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  always_comb begin
    match = (sym == pattern[IDX_W'(len - 4'd1)]);
    // history[k-1] is the symbol accepted k steps before sym.
    for (int k = 1; k < int'(MAX_LEN); k++) begin
      if (k < int'(len)) begin
        if (history[IDX_W'(k - 1)] != pattern[IDX_W'(int'(len) - 1 - k)]) begin
          match = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable symbol-sequence detector with overlap support, a saturating
// match counter and a sticky interrupt flag.
module seq_detect_ctrl #(
  parameter int unsigned SYM_W   = seq_detect_ctrl_pkg::SYM_W,
  parameter int unsigned MAX_LEN = seq_detect_ctrl_pkg::MAX_LEN,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [SYM_W-1:0] cfg_wdata,
  input  logic             cfg_len_we,
  input  logic [3:0]       cfg_len,
  input  logic             arm,
  input  logic             disarm,
  input  logic             data_valid,
  input  logic [SYM_W-1:0] data,
  input  logic             irq_clr,
  output logic             armed,
  output logic             sequence_found,
  output logic [CNT_W-1:0] match_count,
  output logic             irq
);

  import seq_detect_ctrl_pkg::*;

  state_e                       state_q, state_d;
  logic [MAX_LEN-1:0][SYM_W-1:0] hist_q, pattern_q;
  logic [3:0]                   len_q, fill_q, fill_d;
  logic                         arm_go, accept, hunting, win_match, match;

  assign arm_go  = arm && !disarm;
  assign accept  = data_valid && (state_q != StIdle);
  // A FILL that already holds len-1 symbols (only possible with len=1) compares too.
  assign hunting = (state_q == StHunt) || ((state_q == StFill) && (fill_q >= len_q - 4'd1));
  assign match   = accept && hunting && win_match;
  assign armed   = (state_q != StIdle);

  seq_window_cmp #(
    .SYM_W  (SYM_W),
    .MAX_LEN(MAX_LEN)
  ) u_cmp (
    .history(hist_q),
    .sym    (data),
    .pattern(pattern_q),
    .len    (len_q),
    .match  (win_match)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (disarm) begin
      state_d = StIdle;
    end else if (arm) begin
      state_d = StFill;
      fill_d  = '0;
    end else if (accept && (state_q == StFill)) begin
      fill_d = fill_q + 4'd1;
      if (fill_q + 4'd1 >= len_q - 4'd1) begin
        state_d = StHunt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      fill_q         <= '0;
      hist_q         <= '0;
      sequence_found <= 1'b0;
      match_count    <= '0;
      irq            <= 1'b0;
      len_q          <= 4'(MAX_LEN);
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        pattern_q[i] <= SYM_W'(DEFAULT_PATTERN[i % int'(seq_detect_ctrl_pkg::MAX_LEN)]);
      end
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      sequence_found <= match;

      if (arm_go) begin
        hist_q <= '0;
      end else if (accept) begin
        hist_q <= {hist_q[MAX_LEN-2:0], data};
      end

      if (arm_go) begin
        match_count <= '0;
      end else if (match && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + 1'b1;
      end

      if (match) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end

      if (state_q == StIdle) begin
        if (cfg_we && (32'(cfg_addr) < MAX_LEN)) begin
          pattern_q[cfg_addr] <= cfg_wdata;
        end
        if (cfg_len_we && (cfg_len != 4'd0) && (32'(cfg_len) <= MAX_LEN)) begin
          len_q <= cfg_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus a random
// sweep compared against a queue-based model of the detector rules.
module tb_seq_detect_ctrl;

  localparam int SYM_W   = 3;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [SYM_W-1:0] cfg_wdata = '0;
  logic             cfg_len_we = 1'b0;
  logic [3:0]       cfg_len = '0;
  logic             arm = 1'b0;
  logic             disarm = 1'b0;
  logic             data_valid = 1'b0;
  logic [SYM_W-1:0] data = '0;
  logic             irq_clr = 1'b0;
  logic             armed;
  logic             sequence_found;
  logic [CNT_W-1:0] match_count;
  logic             irq;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .SYM_W  (SYM_W),
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_len_we    (cfg_len_we),
    .cfg_len       (cfg_len),
    .arm           (arm),
    .disarm        (disarm),
    .data_valid    (data_valid),
    .data          (data),
    .irq_clr       (irq_clr),
    .armed         (armed),
    .sequence_found(sequence_found),
    .match_count   (match_count),
    .irq           (irq)
  );

  int errors = 0;
  int checks = 0;

  int DEF_PAT[MAX_LEN] = '{1, 5, 6, 0, 6, 6, 3, 5};
  int BAD_SEQ[4]       = '{1, 5, 2, 0};

  // Model: accepted symbols since the last arm, kept as a plain queue.
  int m_pat[MAX_LEN];
  int m_len;
  bit m_armed;
  int m_hist[$];
  int m_count;
  bit m_irq;
  bit exp_found;
  int obs_pulses;
  int trace_bad;

  function automatic void model_reset();
    for (int i = 0; i < MAX_LEN; i++) m_pat[i] = DEF_PAT[i];
    m_len   = MAX_LEN;
    m_armed = 0;
    m_hist.delete();
    m_count = 0;
    m_irq   = 0;
  endfunction

  function automatic bit model_window();
    int n = m_hist.size();
    if (n < m_len) return 0;
    for (int k = 0; k < m_len; k++) begin
      if (m_hist[n - m_len + k] != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  // Advance the model by one edge, clock the DUT, sample 1 time unit later.
  task automatic cycle();
    bit arm_go;
    arm_go    = arm && !disarm;
    exp_found = 0;
    if (m_armed && data_valid) begin
      m_hist.push_back(int'(data));
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      exp_found = model_window();
    end
    if (arm_go) m_count = 0;
    else if (exp_found && m_count < (1 << CNT_W) - 1) m_count++;
    if (exp_found) m_irq = 1;
    else if (irq_clr) m_irq = 0;
    if (!m_armed) begin
      if (cfg_we && int'(cfg_addr) < MAX_LEN) m_pat[cfg_addr] = int'(cfg_wdata);
      if (cfg_len_we && cfg_len >= 1 && int'(cfg_len) <= MAX_LEN) m_len = int'(cfg_len);
    end
    if (disarm) m_armed = 0;
    else if (arm) begin
      m_armed = 1;
      m_hist.delete();
    end
    @(posedge clk);
    #1;
    if (sequence_found === 1'b1) obs_pulses++;
    if (sequence_found !== exp_found) trace_bad++;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    cycle();
    disarm = 1'b0;
  endtask

  task automatic send(input int sym, input int gaps);
    data_valid = 1'b1;
    data       = SYM_W'(sym);
    cycle();
    data_valid = 1'b0;
    for (int g = 0; g < gaps; g++) cycle();
  endtask

  task automatic write_slot(input int addr, input int val);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = SYM_W'(val);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic write_len(input int len);
    cfg_len_we = 1'b1;
    cfg_len    = 4'(len);
    cycle();
    cfg_len_we = 1'b0;
  endtask

  task automatic clear_trace();
    obs_pulses = 0;
    trace_bad  = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #12;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL reset_armed: got %b expected 0", armed);
    end
    checks++;
    if (sequence_found !== 1'b0) begin
      errors++; $display("FAIL reset_found: got %b expected 0", sequence_found);
    end
    checks++;
    if (match_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", match_count);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_default_pattern();
    clear_trace();
    pulse_arm();
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL default_armed: got %b expected 1", armed);
    end
    for (int i = 0; i < MAX_LEN - 1; i++) send(DEF_PAT[i], 0);
    send(DEF_PAT[MAX_LEN-1], 0);
    checks++;
    if (sequence_found !== 1'b1) begin
      errors++; $display("FAIL default_pulse_timing: got %b expected 1", sequence_found);
    end
    cycle();
    checks++;
    if (obs_pulses !== 1) begin
      errors++; $display("FAIL default_pulses: got %0d expected 1", obs_pulses);
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++; $display("FAIL default_count: got %0d expected 1", match_count);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL default_irq: got %b expected 1", irq);
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++; $display("FAIL default_trace: got %0d bad cycles expected 0", trace_bad);
    end
  endtask

  task automatic test_wrong_stream();
    clear_trace();
    pulse_arm();
    for (int i = 0; i < 4; i++) send(BAD_SEQ[i], 0);
    cycle();
    checks++;
    if (obs_pulses !== 0) begin
      errors++; $display("FAIL wrong_pulses: got %0d expected 0", obs_pulses);
    end
    checks++;
    if (match_count !== 8'd0) begin
      errors++; $display("FAIL wrong_count: got %0d expected 0", match_count);
    end
  endtask

  task automatic test_overlap_len2();
    clear_trace();
    pulse_disarm();
    write_len(2);
    write_slot(0, 3);
    write_slot(1, 3);
    pulse_arm();
    for (int i = 0; i < 4; i++) send(3, 0);
    cycle();
    checks++;
    if (obs_pulses !== 3) begin
      errors++; $display("FAIL overlap_pulses: got %0d expected 3", obs_pulses);
    end
    checks++;
    if (match_count !== 8'd3) begin
      errors++; $display("FAIL overlap_count: got %0d expected 3", match_count);
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++; $display("FAIL overlap_trace: got %0d bad cycles expected 0", trace_bad);
    end
  endtask

  task automatic test_valid_gaps();
    pulse_disarm();
    write_len(MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) write_slot(i, DEF_PAT[i]);
    write_len(0);
    write_slot(0, DEF_PAT[0]);
    clear_trace();
    pulse_arm();
    for (int i = 0; i < MAX_LEN - 1; i++) send(DEF_PAT[i], 2);
    send(DEF_PAT[MAX_LEN-1], 0);
    checks++;
    if (sequence_found !== 1'b1) begin
      errors++; $display("FAIL gaps_pulse_timing: got %b expected 1", sequence_found);
    end
    cycle();
    cycle();
    checks++;
    if (obs_pulses !== 1) begin
      errors++; $display("FAIL gaps_pulses: got %0d expected 1", obs_pulses);
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++; $display("FAIL gaps_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_irq_clr();
    pulse_disarm();
    write_len(2);
    write_slot(0, 3);
    write_slot(1, 3);
    pulse_arm();
    irq_clr = 1'b1;
    cycle();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear_idle: got %b expected 0", irq);
    end
    send(3, 0);
    irq_clr = 1'b1;
    send(3, 0);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_clr_vs_match: got %b expected 1", irq);
    end
    irq_clr = 1'b1;
    cycle();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_clr_alone: got %b expected 0", irq);
    end
  endtask

  task automatic test_reset_midseq();
    do_reset();
    clear_trace();
    pulse_arm();
    for (int i = 0; i < 5; i++) send(DEF_PAT[i], 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got armed=%b expected 0", armed);
    end
    #2;
    reset_n = 1'b1;
    for (int i = 5; i < MAX_LEN; i++) send(DEF_PAT[i], 0);
    cycle();
    checks++;
    if (obs_pulses !== 0) begin
      errors++; $display("FAIL midreset_pulses: got %0d expected 0", obs_pulses);
    end
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL midreset_armed: got %b expected 0", armed);
    end
    pulse_arm();
    write_slot(0, 7);
    write_len(2);
    clear_trace();
    pulse_arm();
    for (int i = 0; i < MAX_LEN; i++) send(DEF_PAT[i], 0);
    cycle();
    checks++;
    if (obs_pulses !== 1) begin
      errors++; $display("FAIL cfg_locked_pulses: got %0d expected 1", obs_pulses);
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++; $display("FAIL cfg_locked_trace: got %0d bad cycles expected 0", trace_bad);
    end
  endtask

  task automatic test_random();
    int pulses_model;
    do_reset();
    write_len(3);
    for (int i = 0; i < 3; i++) write_slot(i, int'($urandom_range(0, 1)));
    pulse_arm();
    pulses_model = 0;
    for (int n = 0; n < 600; n++) begin
      data_valid = ($urandom_range(0, 9) < 7);
      data       = SYM_W'($urandom_range(0, 1));
      arm        = ($urandom_range(0, 99) < 2);
      disarm     = ($urandom_range(0, 99) < 2);
      irq_clr    = ($urandom_range(0, 99) < 5);
      cfg_we     = ($urandom_range(0, 99) < 4);
      cfg_addr   = 3'($urandom_range(0, 7));
      cfg_wdata  = SYM_W'($urandom_range(0, 1));
      cfg_len_we = ($urandom_range(0, 99) < 3);
      cfg_len    = 4'($urandom_range(0, 15));
      cycle();
      if (exp_found) pulses_model++;
      checks++;
      if (sequence_found !== exp_found) begin
        errors++; $display("FAIL rand_found[%0d]: got %b expected %b", n, sequence_found, exp_found);
      end
      checks++;
      if (int'(match_count) !== m_count) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, match_count, m_count);
      end
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq, m_irq);
      end
      checks++;
      if (armed !== m_armed) begin
        errors++; $display("FAIL rand_armed[%0d]: got %b expected %b", n, armed, m_armed);
      end
    end
    {data_valid, arm, disarm, irq_clr, cfg_we, cfg_len_we} = '0;
    checks++;
    if (pulses_model == 0) begin
      errors++; $display("FAIL rand_activity: got %0d model matches expected >0", pulses_model);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_pattern();
    test_wrong_stream();
    test_overlap_len2();
    test_valid_gaps();
    test_irq_clr();
    test_reset_midseq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter SYM_W, default 3, symbol width in bits.
REQ-002 Parameter MAX_LEN, default 8, pattern slots.
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  pattern slot write strobe.
REQ-007 cfg_addr  in  3  pattern slot index; slot 0 = first symbol of the sequence.
REQ-008 cfg_wdata  in  SYM_W  pattern symbol value.
REQ-009 cfg_len_we  in  1  length write strobe.
REQ-010 cfg_len  in  4  pattern length, 1..MAX_LEN.
REQ-011 arm  in  1  single-cycle start pulse.
REQ-012 disarm  in  1  single-cycle stop pulse.
REQ-013 data_valid  in  1  qualifies data.
REQ-014 data  in  SYM_W  input symbol stream.
REQ-015 irq_clr  in  1  clears irq.
REQ-016 armed  out  1  high in FILL or HUNT.
REQ-017 sequence_found  out  1  one-cycle registered match pulse.
REQ-018 match_count  out  CNT_W  saturating match count.
REQ-019 irq  out  1  sticky match flag.

Function
REQ-020 FSM states: IDLE, FILL, HUNT; encoding and reset state IDLE.
REQ-021 IDLE -> FILL on arm; FILL/HUNT -> IDLE on disarm; disarm wins when arm and disarm are both high.
REQ-022 arm in FILL or HUNT restarts: history cleared, fill count 0, state FILL.
REQ-023 On arm, match_count clears to 0.
REQ-024 History: MAX_LEN x SYM_W shift register; shifts in data only when data_valid is high and state is FILL or HUNT.
REQ-025 FILL counts accepted symbols; transitions to HUNT on the edge accepting symbol number len-1, so the len-th symbol is compared in HUNT.
REQ-026 Match condition in HUNT: data_valid high and data, together with the previous len-1 accepted symbols, equals slots 0..len-1 in order.
REQ-027 Overlapping matches are detected; history is not flushed after a match.
REQ-028 sequence_found is high exactly the cycle after the edge accepting the final matching symbol, and low otherwise.
REQ-029 Each match increments match_count; it holds at 2^CNT_W-1 when saturated.
REQ-030 Each match sets irq. irq_clr clears it. A match in the same cycle as irq_clr leaves irq set.
REQ-031 Cycles with data_valid low do not advance history or fill count.
REQ-032 cfg_we and cfg_len_we take effect only in IDLE and are ignored otherwise.
REQ-033 cfg_len values of 0 or greater than MAX_LEN are ignored and the previous length is kept.
REQ-034 cfg_addr values of MAX_LEN or above are ignored.
REQ-035 The output armed is combinational from the state register. All other outputs are registered.

Reset
REQ-036 While reset_n is low:
- state = IDLE
- history = 0
- fill count = 0
- sequence_found = 0
- match_count = 0
- irq = 0
- len = 8
- pattern slots 0..7 = 001, 101, 110, 000, 110, 110, 011, 101
REQ-037 Reset asserted mid-sequence aborts immediately. After release, the block does not detect until the next arm.

Structure
REQ-038 A shared package holds the FSM state typedef, SYM_W, MAX_LEN, and the default pattern constant array.
REQ-039 The window comparator is sub-module seq_window_cmp: combinational; inputs are history, current symbol, pattern and len; output is a match bit.

Verification
REQ-040 Default pattern: reset, arm, feed 001,101,110,000,110,110,011,101 -> sequence_found pulses once, 1 cycle after the 8th symbol; match_count=1; irq=1.
REQ-041 Incorrect stream: feed 001,101,010,000 -> sequence_found stays 0; match_count stays 0.
REQ-042 Program len=2 with pattern 011,011 in IDLE, then arm and feed 011 x4 -> 3 pulses (overlap) and match_count=3.
REQ-043 Feed the default pattern with data_valid low for 2 cycles between each symbol -> exactly one pulse, after the 8th valid symbol.
REQ-044 irq_clr asserted on the same cycle as a match -> irq remains 1. irq_clr alone -> irq=0 next cycle.
REQ-045 Reset asserted after 5 pattern symbols, then the remaining 3 symbols fed without arm -> no pulse, armed=0; cfg_we while armed leaves the pattern unchanged.
